// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit with registered result and done pulse.
// Ports: clk, rst_n (async active-low), start, funct3, op1, op2, flush -> busy, done, result.
// Multiply is an unsigned shift-add over magnitudes. Divide is restoring division.
// The sign is corrected on the final iteration edge.
module md_unit #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         funct3,
    input  logic [D_WIDTH-1:0] op1,
    input  logic [D_WIDTH-1:0] op2,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] result
);
    localparam int W  = D_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;

    logic [1:0]     state;
    logic [2:0]     f3;
    logic           s1, s2;
    logic [W-1:0]   mag;
    logic [2*W-1:0] acc;
    logic [W:0]     rem;
    logic [CW-1:0]  cnt;

    logic           sg1, sg2, dz, ovf, sp;
    logic [W-1:0]   a1, a2, sres, q, r, fin;
    logic [W:0]     madd, rsh, diff, rem_n;
    logic [2*W-1:0] mul_n, div_n, acc_n, prod;

    always_comb begin
        sg1   = funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b100 || funct3 == 3'b110;
        sg2   = funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110;
        a1    = (sg1 && op1[W-1]) ? -op1 : op1;
        a2    = (sg2 && op2[W-1]) ? -op2 : op2;
        dz    = op2 == '0;
        ovf   = !funct3[0] && op1 == {1'b1, {(W-1){1'b0}}} && op2 == '1;
        sp    = funct3[2] && (dz || ovf);
        // On overflow the quotient equals the dividend itself.
        sres  = dz ? (funct3[1] ? op1 : '1) : (funct3[1] ? '0 : op1);
        // Multiplier sits in acc low half and shifts out as the product shifts in.
        madd  = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? mag : {W{1'b0}}};
        mul_n = {madd, acc[W-1:1]};
        // Dividend shifts out of acc low half and quotient bits shift in.
        rsh   = {rem[W-1:0], acc[W-1]};
        diff  = rsh - {1'b0, mag};
        rem_n = diff[W] ? rsh : diff;
        div_n = {acc[2*W-1:W], acc[W-2:0], ~diff[W]};
        acc_n = f3[2] ? div_n : mul_n;
        prod  = (s1 ^ s2) ? -acc_n : acc_n;
        q     = (s1 ^ s2) ? -acc_n[W-1:0] : acc_n[W-1:0];
        r     = s1 ? -rem_n[W-1:0] : rem_n[W-1:0];
        fin   = f3[2] ? (f3[1] ? r : q) : (f3 == 3'b000 ? prod[W-1:0] : prod[2*W-1:W]);
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            f3     <= '0;
            s1     <= 1'b0;
            s2     <= 1'b0;
            mag    <= '0;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    f3    <= funct3;
                    s1    <= sg1 & op1[W-1];
                    s2    <= sg2 & op2[W-1];
                    mag   <= funct3[2] ? a2 : a1;
                    acc   <= {{W{1'b0}}, funct3[2] ? a1 : a2};
                    rem   <= '0;
                    cnt   <= CW'(W);
                    state <= sp ? DONE : CALC;
                    if (sp) result <= sres;
                end
                CALC: begin
                    acc <= acc_n;
                    rem <= rem_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result <= fin;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        busy, done;
    logic [31:0] result;
    int checks = 0, errors = 0;

    md_unit #(.D_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Issue one request, scramble the inputs after acceptance, wait (bounded) for done.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bc);
        @(negedge clk);
        start = 1'b1; funct3 = f; op1 = a; op2 = b;
        @(posedge clk);
        #1 start = 1'b0; funct3 = 3'($urandom); op1 = $urandom; op2 = $urandom;
        lat = 0; bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
            if (done) break;
        end
        if (!done) lat = -1;
        res = result;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, bc;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL mul_busy_cycles got %0d want 33", bc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_idle_after got %b want 0", busy); end
    endtask

    task automatic test_mulh();
        logic [31:0] r; int lat, bc;
        run_op(3'b001, 32'h80000000, 32'h80000000, r, lat, bc);
        checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL mulh got %h want 40000000", r); end
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", r); end
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu got %h want ffffffff", r); end
        run_op(3'b010, 32'h00000002, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL mulhsu_pos got %h want 00000001", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat, bc;
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div got %h want fffffffd", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem got %h want ffffffff", r); end
        run_op(3'b101, 32'hFFFFFFF9, 32'd2, r, lat, bc);
        checks++; if (r !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu got %h want 7ffffffc", r); end
        run_op(3'b111, 32'hFFFFFFF9, 32'd2, r, lat, bc);
        checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL remu got %h want 00000001", r); end
        run_op(3'b110, 32'd7, 32'hFFFFFFFE, r, lat, bc);
        checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL rem_pos_dividend got %h want 00000001", r); end
    endtask

    task automatic test_corner();
        logic [31:0] r; int lat, bc;
        run_op(3'b101, 32'd5, 32'd0, r, lat, bc);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_by0 got %h want ffffffff", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL divu_by0_latency got %0d want 1", lat); end
        run_op(3'b110, 32'd5, 32'd0, r, lat, bc);
        checks++; if (r !== 32'h00000005) begin errors++; $display("FAIL rem_by0 got %h want 00000005", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL rem_by0_latency got %0d want 1", lat); end
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h want 80000000", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL div_ovf_latency got %0d want 1", lat); end
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL rem_ovf got %h want 00000000", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL rem_ovf_latency got %0d want 1", lat); end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op1 = 32'd7; op2 = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin start = 1'b1; funct3 = 3'b000; op1 = 32'd100; op2 = 32'd100; end
            if (lat == 6) start = 1'b0;
            if (done) break;
        end
        checks++; if (!done || result !== 32'd21) begin errors++; $display("FAIL ignore_start_result got %h want 00000015", result); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_start_latency got %0d want 33", lat); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_queued busy %b want 0", busy); end
    endtask

    task automatic test_flush();
        int nd;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        checks++; if (result !== 32'd21) begin errors++; $display("FAIL flush_result got %h want 00000015", result); end
        nd = 0;
        repeat (40) begin @(negedge clk); if (done) nd++; end
        checks++; if (nd !== 0) begin errors++; $display("FAIL flush_done got %0d pulses want 0", nd); end
    endtask

    task automatic test_flush_start();
        int nb;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op1 = 32'd2; op2 = 32'd2;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        nb = 0;
        repeat (5) begin @(negedge clk); if (busy || done) nb++; end
        checks++; if (nb !== 0) begin errors++; $display("FAIL flush_start_accepted got %0d busy cycles want 0", nb); end
        checks++; if (result !== 32'd21) begin errors++; $display("FAIL flush_start_result got %h want 00000015", result); end
    endtask

    task automatic test_async_reset();
        logic [31:0] r; int lat, bc;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op1 = 32'd9; op2 = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_done got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL async_result got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b011, 32'd3, 32'd5, r, lat, bc);
        checks++; if (r !== 32'h0 || lat !== 33) begin errors++; $display("FAIL post_reset_mulhu got %h lat %0d want 0 lat 33", r, lat); end
        run_op(3'b000, 32'd3, 32'd5, r, lat, bc);
        checks++; if (r !== 32'd15) begin errors++; $display("FAIL post_reset_mul got %h want 0000000f", r); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_corner();
        test_ignore_start();
        test_flush();
        test_flush_start();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
